// File: rtl/i2c_cfg_seq.sv
// Table-driven I2C configuration sequencer: walks a register ROM and issues writes, with retry/backoff.
// Optional write-readback verification is compiled in with `define I2C_CFG_VERIFY_EN.
module i2c_cfg_seq #(
  parameter  int N_ENTRIES      = 64,
  parameter  int MAX_RETRY      = 3,
  parameter  int BACKOFF_CYCLES = 1000,
  parameter  int DELAY_UNIT     = 100000,
  localparam int IDXW           = $clog2(N_ENTRIES)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic [IDXW-1:0] tbl_idx_o,
  input  logic [23:0]     tbl_data_i,
  output logic [6:0]      cmd_dev_o,
  output logic [7:0]      cmd_reg_o,
  output logic [7:0]      cmd_data_o,
  output logic            cmd_wr_o,
  output logic            cmd_req_o,
  input  logic            cmd_ack_i,
  input  logic            cmd_err_i,
  input  logic [7:0]      cmd_rddata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            fail_o,
  output logic [IDXW-1:0] fail_idx_o
);

  localparam int              RW           = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]   RETRY_LIMIT  = RW'(MAX_RETRY);
  localparam logic [31:0]     DELAY_MULT   = 32'(DELAY_UNIT);
  localparam logic [31:0]     BACKOFF_LOAD = (BACKOFF_CYCLES > 0) ? 32'(BACKOFF_CYCLES - 1) : 32'd0;
  localparam logic [IDXW-1:0] LAST_IDX     = IDXW'(N_ENTRIES - 1);
  localparam logic [6:0]      DEV_END      = 7'h00;
  localparam logic [6:0]      DEV_DELAY    = 7'h7F;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WRITE,
`ifdef I2C_CFG_VERIFY_EN
    S_VERIFY,
`endif
    S_DELAY,
    S_BACKOFF,
    S_DONE,
    S_FAIL
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] tblIdx_q, tblIdx_d;
  logic [IDXW-1:0] failIdx_q, failIdx_d;
  logic [6:0]      cmdDev_q, cmdDev_d;
  logic [7:0]      cmdReg_q, cmdReg_d;
  logic [7:0]      cmdData_q, cmdData_d;
  logic [RW-1:0]   retryCnt_q, retryCnt_d;
  logic [31:0]     waitCnt_q, waitCnt_d;

  logic [RW-1:0]   retryInc;
  logic            attemptDone;
  logic            attemptFailed;
  logic            advance;

  // Reserved table bit (and readback data when verification is off) never affect behaviour.
`ifdef I2C_CFG_VERIFY_EN
  logic unusedInputs;
  assign unusedInputs = tbl_data_i[23];
`else
  logic unusedInputs;
  assign unusedInputs = ^{tbl_data_i[23], cmd_rddata_i};
`endif

  assign retryInc = retryCnt_q + RW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      tblIdx_q   <= '0;
      failIdx_q  <= '0;
      cmdDev_q   <= '0;
      cmdReg_q   <= '0;
      cmdData_q  <= '0;
      retryCnt_q <= '0;
      waitCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tblIdx_q   <= tblIdx_d;
      failIdx_q  <= failIdx_d;
      cmdDev_q   <= cmdDev_d;
      cmdReg_q   <= cmdReg_d;
      cmdData_q  <= cmdData_d;
      retryCnt_q <= retryCnt_d;
      waitCnt_q  <= waitCnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tblIdx_d      = tblIdx_q;
    failIdx_d     = failIdx_q;
    cmdDev_d      = cmdDev_q;
    cmdReg_d      = cmdReg_q;
    cmdData_d     = cmdData_q;
    retryCnt_d    = retryCnt_q;
    waitCnt_d     = waitCnt_q;
    attemptDone   = 1'b0;
    attemptFailed = 1'b0;
    advance       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          state_d    = S_FETCH;
          tblIdx_d   = '0;
          retryCnt_d = '0;
          failIdx_d  = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      // The ROM answers one cycle after the address, so the entry is valid here.
      S_DECODE: begin
        if (tbl_data_i[22:16] == DEV_END) begin
          state_d = S_DONE;
        end else if (tbl_data_i[22:16] == DEV_DELAY) begin
          state_d   = S_DELAY;
          waitCnt_d = 32'(tbl_data_i[7:0]) * DELAY_MULT;
        end else begin
          state_d   = S_WRITE;
          cmdDev_d  = tbl_data_i[22:16];
          cmdReg_d  = tbl_data_i[15:8];
          cmdData_d = tbl_data_i[7:0];
        end
      end
      S_WRITE: begin
        if (cmd_err_i) begin
          attemptFailed = 1'b1;
        end else if (cmd_ack_i) begin
`ifdef I2C_CFG_VERIFY_EN
          state_d = S_VERIFY;
`else
          attemptDone = 1'b1;
`endif
        end
      end
`ifdef I2C_CFG_VERIFY_EN
      S_VERIFY: begin
        if (cmd_err_i || (cmd_ack_i && (cmd_rddata_i != cmdData_q))) begin
          attemptFailed = 1'b1;
        end else if (cmd_ack_i) begin
          attemptDone = 1'b1;
        end
      end
`endif
      // Leaving on the cycle the count reaches zero keeps the delay within a few cycles of val*DELAY_UNIT.
      S_DELAY: begin
        if (waitCnt_q <= 32'd1) begin
          waitCnt_d = '0;
          advance   = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q - 32'd1;
        end
      end
      S_BACKOFF: begin
        if (waitCnt_q == 32'd0) begin
          state_d = S_WRITE;
        end else begin
          waitCnt_d = waitCnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (attemptDone) begin
      retryCnt_d = '0;
      advance    = 1'b1;
    end

    if (attemptFailed) begin
      retryCnt_d = retryInc;
      if (retryInc == RETRY_LIMIT) begin
        state_d   = S_FAIL;
        failIdx_d = tblIdx_q;
      end else begin
        state_d   = S_BACKOFF;
        waitCnt_d = BACKOFF_LOAD;
      end
    end

    // The table never wraps: running off the last entry counts as completion.
    if (advance) begin
      if (tblIdx_q == LAST_IDX) begin
        state_d = S_DONE;
      end else begin
        state_d  = S_FETCH;
        tblIdx_d = tblIdx_q + IDXW'(1);
      end
    end
  end

  assign tbl_idx_o  = tblIdx_q;
  assign fail_idx_o = failIdx_q;
  assign cmd_dev_o  = cmdDev_q;
  assign cmd_reg_o  = cmdReg_q;
  assign cmd_data_o = cmdData_q;
  assign cmd_wr_o   = (state_q == S_WRITE);
`ifdef I2C_CFG_VERIFY_EN
  assign cmd_req_o  = (state_q == S_WRITE) || (state_q == S_VERIFY);
`else
  assign cmd_req_o  = (state_q == S_WRITE);
`endif
  assign busy_o     = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
  assign done_o     = (state_q == S_DONE);
  assign fail_o     = (state_q == S_FAIL);

endmodule

// File: doc/i2c_cfg_seq.md
Name: i2c_cfg_seq

Overview:
Table-driven I2C configuration sequencer that brings up the HDMI transmitter and video ADC over the shared I2C master after power-up or hot-plug.
- Walks a register table one entry at a time (write, delay or end marker) and issues one single-register transaction per write entry.
- Retries failed transactions with backoff and reports done or fail status.
- Sits between a table ROM and the I2C arbiter's command port.

Parameters:
N_ENTRIES, 64, table depth; IDXW = clog2(N_ENTRIES)
MAX_RETRY, 3, attempts per entry before FAIL (must be >= 1)
BACKOFF_CYCLES, 1000, idle cycles between a failed attempt and its retry
DELAY_UNIT, 100000, clk cycles per delay-entry count (1 ms at 100 MHz)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse; begin sequence at entry 0
tbl_idx  out  IDXW  table read address
tbl_data  in  24  table entry, valid 1 cycle after tbl_idx: [23] reserved 0, [22:16] dev, [15:8] reg, [7:0] val
cmd_dev  out  7  I2C 7-bit device address
cmd_reg  out  8  register address
cmd_data  out  8  write data
cmd_wr  out  1  1 = write, 0 = read
cmd_req  out  1  transaction request
cmd_ack  in  1  single-cycle pulse: transaction complete
cmd_err  in  1  single-cycle pulse: NACK or arbitration error
cmd_rddata  in  8  read data, valid with cmd_ack on reads
busy  out  1  sequence in progress
done  out  1  sequence completed, sticky
fail  out  1  sequence aborted, sticky
fail_idx  out  IDXW  entry that exhausted its retries

Behaviour:
- Reset: state IDLE. All outputs 0, including tbl_idx, retry count and delay counter. Async assert; deassert is sampled on clk.
- States: IDLE, FETCH, DECODE, WRITE, (VERIFY), DELAY, BACKOFF, DONE, FAIL.
- Start:
  - start in IDLE, DONE or FAIL → FETCH next cycle; clear done and fail; tbl_idx = 0; retry count = 0; busy = 1.
  - start while busy is ignored.
- FETCH: hold tbl_idx for 1 cycle, then DECODE (tbl_data registered in DECODE).
- DECODE:
  - dev = 7'h00 → DONE.
  - dev = 7'h7F → DELAY; counter = val*DELAY_UNIT (32-bit).
  - Otherwise latch dev/reg/val onto cmd_* and go to WRITE.
- WRITE:
  - cmd_req = 1, cmd_wr = 1; cmd_* stable while req is high.
  - On cmd_ack: drop req the next cycle, retry count = 0, advance.
  - On cmd_err: drop req, increment retry count.
    - If count == MAX_RETRY → FAIL, fail_idx = tbl_idx.
    - Otherwise → BACKOFF.
  - ack and err in the same cycle: err wins.
- BACKOFF: count BACKOFF_CYCLES cycles, then WRITE again with the same entry.
- DELAY:
  - Decrement the counter each cycle; at 0, advance.
  - val = 0 → advance the next cycle.
- Advance:
  - If tbl_idx == N_ENTRIES-1 → DONE (table exhausted, no wrap).
  - Otherwise tbl_idx+1 → FETCH.
- DONE: busy = 0, done = 1. FAIL: busy = 0, fail = 1. Both hold until the next start or reset.
- cmd_req is never asserted outside WRITE/VERIFY. At most one transaction is outstanding.
- Reset mid-transaction: cmd_req drops asynchronously; the arbiter must tolerate the abandoned request.
- Entry latency: a write entry that acks immediately costs FETCH(1) + DECODE(1) + WRITE(>=1) cycles.

Optional Feature:
Macro I2C_CFG_VERIFY_EN.
- Defined: after a write ack, enter VERIFY and issue a read (cmd_wr = 0) of the same dev/reg.
  - Ack with cmd_rddata == val → advance.
  - Mismatch or err → counts as one failed attempt (retry from WRITE via BACKOFF, or FAIL at MAX_RETRY).
- Undefined: the VERIFY state and its logic are absent; write ack advances directly.

Test Plan:
1. Table {(0x39,0x41,0x10), (0x39,0x98,0x03), end}, all acked → 2 write transactions in order; done = 1 and busy = 0 after the 2nd ack plus 2 cycles; fail = 0.
2. Entry 1 gets cmd_err on every attempt, MAX_RETRY = 3 → exactly 3 requests, each retry gap >= 1000 cycles; fail = 1, fail_idx = 1; no request for entry 2.
3. Delay entry (0x7F,x,5), DELAY_UNIT = 10 → next cmd_req asserts 50 cycles (±3 fixed overhead) after the delay entry's DECODE. val = 0 → proceeds with no wait.
4. cmd_ack and cmd_err asserted in the same cycle → treated as error; retry count increments; the entry is repeated.
5. start pulsed while busy → ignored, sequence unchanged. start after DONE → done clears, tbl_idx = 0, sequence reruns. rst asserted mid-WRITE → all outputs 0 immediately.
6. I2C_CFG_VERIFY_EN defined, readback 0x11 vs written 0x10 once, then correct → write, read, backoff, write, read; then advance.
